csr_status_reporter: RTL and testbench
======================================

Name: csr_status_reporter

Overview:
Host-side consumer of the CPU's 32-bit tohost `csr` output: the reading end of the same pass/fail handshake the CPU writes.
- Watches `csr`. On the first non-zero value it latches the value and sends an ASCII verdict over an integrated 8N1 UART transmitter.
- Exposes `done`/`pass` flags so on-board self-tests can report results without a simulator.
- Sits at top level beside the Riscv151 core, driven by the same clock.

Parameters:
CLOCK_FREQ, 50_000_000, clock frequency in Hz.
BAUD_RATE, 115_200, serial bit rate.
(Derived, not a parameter: SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer-truncated; 434 at the defaults.)

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous reset, active-low (rst==0 resets on the next rising clk).
csr  input  32  tohost value from the CPU; 0 means no result yet.
serial_out  output  1  UART TX line, idle high.
busy  output  1  high while a message is being shifted out.
done  output  1  high once the message has completed; sticky until re-arm.
pass  output  1  valid when done: 1 iff the latched code == 32'h0000_0001.
code  output  32  latched csr value; 0 until latched.

Behaviour:
- Reset values: serial_out=1, busy=0, done=0, pass=0, code=0. FSM goes to IDLE; bit, character and baud counters are cleared.
- Reset mid-transmission: serial_out is high from the cycle after reset is sampled; the partial character is abandoned and nothing is resumed.
- FSM states:
  - IDLE: sample csr each cycle. When csr!=0: latch code<=csr, go to SEND, busy<=1. The start bit (serial_out=0) appears the cycle after the first non-zero sample (1-cycle latency).
  - SEND: shift each character as start(0), data[7:0] LSB first, stop(1), 10 bits total. Each bit holds exactly SYMBOL_EDGE_TIME cycles. The next character's start bit follows the previous stop bit immediately (no idle gap).
  - SEND to DONE: in the cycle after the last stop bit completes, set busy<=0, done<=1, pass<=(code==1).
  - DONE: serial_out=1; outputs hold. When csr is sampled ==0, go to IDLE and clear done, pass and code (re-arm).
- Message when code==1: "PASS\r\n", 6 characters.
- Message when code!=1: "FAIL " followed by code as 8 uppercase hex digits (MSB nibble first, '0'-'9','A'-'F') followed by "\r\n", 15 characters.
- csr changes while in SEND are ignored; the latched code is used throughout.
- csr non-zero on the first cycle after reset: accepted; the message starts the following cycle.
- The baud counter counts 0..SYMBOL_EDGE_TIME-1 and wraps without drift; a bit advances on count==SYMBOL_EDGE_TIME-1.

Optional Feature:
- Macro: CSR_REPORT_CYCLES_EN.
- When defined:
  - A 32-bit cycle counter clears on reset, starts on the first cycle with rst==1, and increments every cycle while in IDLE.
  - The counter freezes when the code is latched and is cleared on re-arm.
  - " C=" plus the counter value as 8 uppercase hex digits is inserted before "\r\n" in both messages (+11 characters).
- When undefined: no counter logic and messages exactly as above.

Test Plan:
All tests use CLOCK_FREQ=1000 and BAUD_RATE=100, giving SYMBOL_EDGE_TIME=10.
1. Hold rst=0 for 5 cycles with csr=0 -> serial_out=1, busy=0, done=0, pass=0, code=0 throughout; no start bit while csr stays 0 after release.
2. Set csr=32'h1 -> start bit the next cycle; bytes 50 41 53 53 0D 0A decoded; 600 cycles later busy falls and done=1, pass=1, code=1.
3. Set csr=32'h0000_002B, then change csr to 5 mid-message -> "FAIL 0000002B\r\n" (1500 cycles); done=1, pass=0, code=32'h2B.
4. After done, drive csr=0 for 1 cycle, then csr=32'hDEAD_BEEF -> done clears; new message "FAIL DEADBEEF\r\n".
5. Pull rst=0 during character 3 of a FAIL message -> serial_out=1 and busy=0 the next cycle; after release with csr held non-zero, the message restarts from 'F'.
6. With CSR_REPORT_CYCLES_EN, release reset and set csr=1 after exactly 32 IDLE cycles -> "PASS C=00000020\r\n" (17 characters, 1700 cycles).

Source files
------------

// File: rtl/csr_status_reporter.sv
// csr_status_reporter: latches the first non-zero tohost value and
// reports PASS/FAIL over an 8N1 UART. Option: CSR_REPORT_CYCLES_EN.
module csr_status_reporter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] csr,
  output logic        serial_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] code
);

  localparam int SYM = CLOCK_FREQ / BAUD_RATE;
  localparam int BW  = (SYM > 1) ? $clog2(SYM) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(SYM - 1);
`ifdef CSR_REPORT_CYCLES_EN
  localparam logic [4:0] TAIL = 5'd13;
`else
  localparam logic [4:0] TAIL = 5'd2;
`endif

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud;
  logic [3:0]    bit_idx;
  logic [4:0]    chr_idx;
  logic [4:0]    body_len;
  logic [4:0]    msg_len;
  logic [4:0]    rel;
  logic [7:0]    ch;
  logic          is_pass;
  logic          bit_end;
  logic          chr_end;
  logic          msg_end;
`ifdef CSR_REPORT_CYCLES_EN
  logic [31:0]   cycles;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // d = 0 selects the most significant nibble
  function automatic logic [3:0] nib(input logic [31:0] v,
                                     input logic [2:0]  d);
    logic [31:0] s;
    s = v >> {3'd7 - d, 2'b00};
    return s[3:0];
  endfunction

  assign is_pass = (code == 32'h1);
  assign bit_end = (baud == BAUD_LAST);
  assign chr_end = bit_end && (bit_idx == 4'd9);
  assign msg_end = chr_end && (chr_idx == msg_len - 5'd1);

  assign busy = (state == SEND);
  assign done = (state == DONE);
  assign pass = done && is_pass;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // next-state: latch, send, hold until csr returns to zero
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (csr != 32'h0) state_n = SEND;
      SEND:    if (msg_end)      state_n = DONE;
      DONE:    if (csr == 32'h0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // code latch plus baud, bit and character counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      code    <= '0;
      baud    <= '0;
      bit_idx <= '0;
      chr_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (csr != 32'h0) code <= csr;
          baud    <= '0;
          bit_idx <= '0;
          chr_idx <= '0;
        end
        SEND: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              chr_idx <= chr_idx + 5'd1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DONE: if (csr == 32'h0) code <= '0;
        default: ;
      endcase
    end
  end

`ifdef CSR_REPORT_CYCLES_EN
  // idle-cycle counter: frozen once latched, cleared on re-arm
  always_ff @(posedge clk) begin
    if (!rst)
      cycles <= '0;
    else if (state == IDLE && csr == 32'h0)
      cycles <= cycles + 32'd1;
    else if (state == DONE && csr == 32'h0)
      cycles <= '0;
  end
`endif

  // message character for the current index
  always_comb begin
    body_len = is_pass ? 5'd4 : 5'd13;
    msg_len  = body_len + TAIL;
    rel      = chr_idx - body_len;
    ch       = 8'h0A;
    if (chr_idx < body_len) begin
      if (is_pass) begin
        unique case (chr_idx[1:0])
          2'd0:    ch = "P";
          2'd1:    ch = "A";
          default: ch = "S";
        endcase
      end else if (chr_idx < 5'd5) begin
        unique case (chr_idx[2:0])
          3'd0:    ch = "F";
          3'd1:    ch = "A";
          3'd2:    ch = "I";
          3'd3:    ch = "L";
          default: ch = " ";
        endcase
      end else begin
        ch = hex_ascii(nib(code, 3'(chr_idx - 5'd5)));
      end
`ifdef CSR_REPORT_CYCLES_EN
    end else if (rel == 5'd0) begin
      ch = " ";
    end else if (rel == 5'd1) begin
      ch = "C";
    end else if (rel == 5'd2) begin
      ch = "=";
    end else if (rel < 5'd11) begin
      ch = hex_ascii(nib(cycles, 3'(rel - 5'd3)));
    end else if (rel == 5'd11) begin
      ch = 8'h0D;
    end
`else
    end else if (rel == 5'd0) begin
      ch = 8'h0D;
    end
`endif
  end

  // line driver: start, 8 data LSB first, stop
  always_comb begin
    serial_out = 1'b1;
    if (state == SEND) begin
      if (bit_idx == 4'd0)
        serial_out = 1'b0;
      else if (bit_idx < 4'd9)
        serial_out = ch[3'(bit_idx - 4'd1)];
    end
  end

endmodule

// File: tb/tb_csr_status_reporter.sv
// tb_csr_status_reporter: directed checks of the tohost UART reporter
// at CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles per bit).
module tb_csr_status_reporter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] csr = 32'h0;
  logic        serial_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] code;

  int errors = 0;
  int checks = 0;

  csr_status_reporter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .csr       (csr),
    .serial_out(serial_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .code      (code)
  );

  always #5 clk = ~clk;

  // receive one 8N1 frame sampling bit centres on falling edges
  task automatic uart_rx(output logic [7:0] b, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b  = 8'h00;
    while (serial_out !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (serial_out !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (5) @(negedge clk);
    if (serial_out !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = serial_out;
    end
    repeat (10) @(negedge clk);
    if (serial_out !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    csr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_out, busy, done, pass} !== 4'b1000 || code !== 32'h0) begin
        errors++;
        $display("FAIL reset%0d got so/b/d/p=%b%b%b%b code=%h want 1000 0",
                 i, serial_out, busy, done, pass, code);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle%0d got so=%b busy=%b want 1 0",
                 i, serial_out, busy);
      end
    end
  endtask

`ifdef CSR_REPORT_CYCLES_EN
  task automatic test_cycles;
    string exp = "PASS C=00000020\r\n";
    logic [7:0] b;
    bit ok;
    rst = 1'b0;
    csr = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    repeat (32) @(negedge clk);
    csr = 32'h1;
    @(negedge clk);
    for (int i = 0; i < exp.len(); i++) begin
      uart_rx(b, ok);
      checks++;
      if (!ok || b !== exp[i]) begin
        errors++;
        $display("FAIL cyc_char%0d got=%h ok=%0d want=%h", i, b, ok, exp[i]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b011) begin
      errors++;
      $display("FAIL cyc_end got b/d/p=%b%b%b want 011", busy, done, pass);
    end
  endtask
`else
  task automatic test_pass;
    string exp = "PASS\r\n";
    logic [7:0] b;
    bit ok;
    csr = 32'h1;
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pass_start got so=%b busy=%b want 0 1", serial_out, busy);
    end
    for (int i = 0; i < exp.len(); i++) begin
      uart_rx(b, ok);
      checks++;
      if (!ok || b !== exp[i]) begin
        errors++;
        $display("FAIL pass_char%0d got=%h ok=%0d want=%h", i, b, ok, exp[i]);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL pass_len got busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b011 || code !== 32'h1) begin
      errors++;
      $display("FAIL pass_end got b/d/p=%b%b%b code=%h want 011 1",
               busy, done, pass, code);
    end
  endtask

  task automatic test_fail_ignore;
    string exp = "FAIL 0000002B\r\n";
    logic [7:0] b;
    bit ok;
    csr = 32'h0;
    @(negedge clk);
    csr = 32'h2B;
    @(negedge clk);
    for (int i = 0; i < exp.len(); i++) begin
      uart_rx(b, ok);
      checks++;
      if (!ok || b !== exp[i]) begin
        errors++;
        $display("FAIL fail_char%0d got=%h ok=%0d want=%h", i, b, ok, exp[i]);
      end
      if (i == 1) csr = 32'h5;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fail_len got busy=%b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b010 || code !== 32'h2B) begin
      errors++;
      $display("FAIL fail_end got b/d/p=%b%b%b code=%h want 010 2b",
               busy, done, pass, code);
    end
  endtask

  task automatic test_rearm;
    string exp = "FAIL DEADBEEF\r\n";
    logic [7:0] b;
    bit ok;
    csr = 32'h0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || code !== 32'h0) begin
      errors++;
      $display("FAIL rearm_clear got d=%b p=%b code=%h want 0 0 0",
               done, pass, code);
    end
    csr = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int i = 0; i < exp.len(); i++) begin
      uart_rx(b, ok);
      checks++;
      if (!ok || b !== exp[i]) begin
        errors++;
        $display("FAIL rearm_char%0d got=%h ok=%0d want=%h", i, b, ok, exp[i]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b010 || code !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rearm_end got b/d/p=%b%b%b code=%h want 010 deadbeef",
               busy, done, pass, code);
    end
  endtask

  task automatic test_reset_mid;
    string exp = "FAIL 0000002B\r\n";
    logic [7:0] b;
    bit ok;
    csr = 32'h0;
    @(negedge clk);
    csr = 32'h2B;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      uart_rx(b, ok);
      checks++;
      if (!ok || b !== exp[i]) begin
        errors++;
        $display("FAIL mid_pre%0d got=%h ok=%0d want=%h", i, b, ok, exp[i]);
      end
    end
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({serial_out, busy, done} !== 3'b100 || code !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got so/b/d=%b%b%b code=%h want 100 0",
               serial_out, busy, done, code);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got so=%b busy=%b want 0 1", serial_out, busy);
    end
    for (int i = 0; i < exp.len(); i++) begin
      uart_rx(b, ok);
      checks++;
      if (!ok || b !== exp[i]) begin
        errors++;
        $display("FAIL mid_char%0d got=%h ok=%0d want=%h", i, b, ok, exp[i]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b010 || code !== 32'h2B) begin
      errors++;
      $display("FAIL mid_end got b/d/p=%b%b%b code=%h want 010 2b",
               busy, done, pass, code);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CSR_REPORT_CYCLES_EN
    test_cycles();
`else
    test_pass();
    test_fail_ignore();
    test_rearm();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
